clip_interp_unit: RTL
=====================

CLIP_INTERP_UNIT -- requirements
Module: clip_interp_unit

Interface
REQ-001 Parameter WIDTH, default 32: signed width of numerator, denominator, attributes and results.
REQ-002 Parameter FRAC, default 8: fraction bits of t; ONE = 2^FRAC.
REQ-003 Parameter CHANNELS, default 4: attribute channels interpolated per request.
REQ-004 Parameter CLAMP, default 1: 1 clamps t to [0, ONE]; 0 keeps signed t in [-ONE, ONE].
REQ-005 Ports: clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  request valid.
REQ-008 in_ready  out  1  unit can accept a request.
REQ-009 in_num, in_den  in  WIDTH each  signed t numerator and denominator.
REQ-010 in_v1, in_v2  in  CHANNELS*WIDTH each  packed signed endpoints; channel k at bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_t  out  WIDTH  signed t, FRAC fraction bits.
REQ-014 out_attr  out  CHANNELS*WIDTH  packed interpolated attributes, same layout as in_v1.
REQ-015 out_div_zero  out  1  in_den was zero.

Function
REQ-016 FSM states: IDLE, DIVIDE, INTERP, DONE.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 Accept occurs when in_valid & in_ready; all inputs are registered on accept; input changes afterwards have no effect.
REQ-019 IDLE -> DIVIDE on accept; DIVIDE lasts exactly FRAC+1 cycles; INTERP lasts exactly CHANNELS cycles; then DONE.
REQ-020 DONE -> IDLE on out_ready; outputs are held stable while out_ready = 0.
REQ-021 Latency is fixed: out_valid rises FRAC+CHANNELS+2 cycles after the accept edge, for every operand value.
REQ-022 Sign of t = sign(num) XOR sign(den); magnitudes |num| and |den| are formed at WIDTH+1 bits so that the most negative value is handled correctly.
REQ-023 Division: restoring, one quotient bit per DIVIDE cycle, MSB (weight ONE) first; remainder held at WIDTH+1 bits; result = floor(|num|*ONE/|den|).
REQ-024 If |num| >= |den| and den != 0: magnitude = ONE (saturate); the DIVIDE cycle count does not change.
REQ-025 If den == 0: out_div_zero = 1, t = 0, and the DIVIDE cycle count does not change.
REQ-026 If CLAMP = 1 and signed t < 0: t = 0.
REQ-027 INTERP cycle k computes channel k: attr = v1 + ((v2 - v1) * t >>> FRAC).
REQ-028 Interpolation widths: difference at WIDTH+1 bits; signed product at 2*WIDTH+2 bits; arithmetic shift right; result truncated to WIDTH bits (wraps, no saturation).
REQ-029 Only one request is in flight at a time; in_valid is ignored outside IDLE.
REQ-030 out_ready asserted outside DONE has no effect.

Reset
REQ-031 rst_n low forces IDLE immediately. in_ready = 1, out_valid = 0, out_t = 0, out_attr = 0, out_div_zero = 0.
REQ-032 Reset during DIVIDE, INTERP or DONE discards the in-flight request; no partial result is ever presented.
REQ-033 First accept is possible on the first rising edge with rst_n high.

Verification (WIDTH=32, FRAC=8, CHANNELS=4, CLAMP=1 unless stated)
REQ-034 num=128, den=256, all v1=0, all v2=1000 -> t=128, each attr=500, div_zero=0; out_valid exactly 14 cycles after accept.
REQ-035 CLAMP=0, num=-64, den=256, v1=100, v2=356 -> t=-64, attr=36; with CLAMP=1 -> t=0, attr=100.
REQ-036 num=300, den=256 -> t=256, attr=v2; num=5, den=0 -> div_zero=1, t=0, attr=v1; latency 14 cycles in both cases.
REQ-037 num=-2^31, den=-1 -> t=256 with no overflow; channels hold distinct v1 and v2 values to check per-channel packing order.
REQ-038 out_ready held low for 10 cycles in DONE -> outputs stable and in_ready=0; then one cycle with out_ready high -> IDLE, and a back-to-back request is accepted on the next edge.
REQ-039 rst_n pulsed low during DIVIDE cycle 3 -> in_ready=1 and out_valid=0 asynchronously; the following request completes correctly.

Source files
------------

// File: rtl/clip_interp_unit.sv
// Clip-space interpolation unit: computes a signed fixed-point ratio t = num/den
// with a bit-serial restoring divider, then linearly interpolates CHANNELS packed
// attributes between v1 and v2 one channel per cycle. Fixed latency, one request
// in flight at a time.
module clip_interp_unit #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 8,
    parameter int CHANNELS = 4,
    parameter int CLAMP    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [WIDTH-1:0]      in_num,
    input  logic signed [WIDTH-1:0]      in_den,
    input  logic [CHANNELS*WIDTH-1:0]    in_v1,
    input  logic [CHANNELS*WIDTH-1:0]    in_v2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [WIDTH-1:0]      out_t,
    output logic [CHANNELS*WIDTH-1:0]    out_attr,
    output logic                         out_div_zero
);

    localparam int CW = $clog2(FRAC + CHANNELS + 1) + 1;
    localparam logic [CW-1:0]    DIV_LAST = CW'(FRAC);
    localparam logic [CW-1:0]    INT_LAST = CW'(CHANNELS - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1) << FRAC;

    typedef enum logic [1:0] {IDLE, DIVIDE, INTERP, DONE} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic accept;

    logic [WIDTH:0] num_ext, den_ext, num_mag_in, den_mag_in;
    logic [WIDTH:0] rem, den_mag;
    logic [FRAC-1:0] quo;
    logic neg_r, sat_r, dz_r;
    logic [CHANNELS*WIDTH-1:0] v1_r, v2_r, attr_r;
    logic signed [WIDTH-1:0] t_r;

    logic [WIDTH+1:0] trial;
    logic take;
    logic [FRAC:0] quo_next;
    logic [WIDTH-1:0] mag, t_calc;

    logic signed [WIDTH-1:0] v1_k, v2_k;
    logic signed [WIDTH:0] diff;
    logic signed [2*WIDTH+1:0] prod;
    logic [WIDTH-1:0] attr_k;

    assign accept       = in_valid & in_ready;
    assign out_t        = t_r;
    assign out_attr     = attr_r;
    assign out_div_zero = dz_r;

    // Next-state logic and handshake outputs; ready only when idle, valid only when done
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DIVIDE;
            end
            DIVIDE: begin
                if (cnt == DIV_LAST) state_next = INTERP;
            end
            INTERP: begin
                if (cnt == INT_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any in-flight request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Cycle counter within DIVIDE and INTERP, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state != state_next || state == IDLE || state == DONE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Operand magnitudes one bit wider so the most negative value negates cleanly
    always_comb begin
        num_ext    = {in_num[WIDTH-1], in_num};
        den_ext    = {in_den[WIDTH-1], in_den};
        num_mag_in = num_ext[WIDTH] ? -num_ext : num_ext;
        den_mag_in = den_ext[WIDTH] ? -den_ext : den_ext;
    end

    // One restoring-division step per cycle plus final sign, saturation and clamp of t
    always_comb begin
        trial    = (cnt == '0) ? {1'b0, rem} : {rem, 1'b0};
        take     = trial >= {1'b0, den_mag};
        quo_next = {quo, take};
        if (dz_r)       mag = '0;
        else if (sat_r) mag = ONE;
        else            mag = WIDTH'(quo_next);
        if (neg_r) t_calc = (CLAMP != 0) ? '0 : -mag;
        else       t_calc = mag;
    end

    // Interpolation of the channel currently sitting in the low slice of the endpoint registers
    always_comb begin
        v1_k   = v1_r[WIDTH-1:0];
        v2_k   = v2_r[WIDTH-1:0];
        diff   = {v2_k[WIDTH-1], v2_k} - {v1_k[WIDTH-1], v1_k};
        prod   = {{(WIDTH+1){diff[WIDTH]}}, diff} * {{(WIDTH+2){t_r[WIDTH-1]}}, t_r};
        attr_k = v1_k + WIDTH'(prod >>> FRAC);
    end

    // Datapath: capture on accept, divide, then shift channels through the interpolator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            den_mag <= '0;
            quo     <= '0;
            neg_r   <= 1'b0;
            sat_r   <= 1'b0;
            dz_r    <= 1'b0;
            v1_r    <= '0;
            v2_r    <= '0;
            attr_r  <= '0;
            t_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem     <= num_mag_in;
                        den_mag <= den_mag_in;
                        quo     <= '0;
                        neg_r   <= in_num[WIDTH-1] ^ in_den[WIDTH-1];
                        sat_r   <= num_mag_in >= den_mag_in;
                        dz_r    <= (in_den == '0);
                        v1_r    <= in_v1;
                        v2_r    <= in_v2;
                    end
                end
                DIVIDE: begin
                    rem <= take ? (WIDTH+1)'(trial - {1'b0, den_mag}) : trial[WIDTH:0];
                    quo <= quo_next[FRAC-1:0];
                    if (cnt == DIV_LAST) t_r <= t_calc;
                end
                INTERP: begin
                    attr_r <= (CHANNELS*WIDTH)'({attr_k, attr_r} >> WIDTH);
                    v1_r   <= v1_r >> WIDTH;
                    v2_r   <= v2_r >> WIDTH;
                end
                default: ;
            endcase
        end
    end

endmodule
